// File: rtl/pixel_pkg.sv
// Shared pixel bundle definitions for the threshold -> framebuffer path.
// Used by adaptive_threshold, pixel_write_fifo and the VGA write port.
package pixel_pkg;

    localparam int X_W   = 8;
    localparam int Y_W   = 8;
    localparam int C_W   = 3;
    localparam int PIX_W = X_W + Y_W + 3 * C_W;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] r;
        logic [C_W-1:0] g;
        logic [C_W-1:0] b;
    } pixel_t;

endpackage

// File: rtl/pixel_fifo_mem.sv
// DEPTH x PIX_W register array: synchronous write, asynchronous read.
// Storage is never reset; validity is tracked by the owning FIFO.
module pixel_fifo_mem
    import pixel_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_write_fifo.sv
// Show-ahead elastic buffer feeding the framebuffer writer.
// Optional debug stats when PIXEL_WRITE_FIFO_STATS_EN is defined.
module pixel_write_fifo
    import pixel_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [X_W-1:0]   in_x,
    input  logic [Y_W-1:0]   in_y,
    input  logic [C_W-1:0]   in_r,
    input  logic [C_W-1:0]   in_g,
    input  logic [C_W-1:0]   in_b,
    output logic             in_ready,
    output logic             out_valid,
    output logic [X_W-1:0]   out_x,
    output logic [Y_W-1:0]   out_y,
    output logic [C_W-1:0]   out_r,
    output logic [C_W-1:0]   out_g,
    output logic [C_W-1:0]   out_b,
    input  logic             out_ready,
`ifdef PIXEL_WRITE_FIFO_STATS_EN
    output logic [AW:0]      max_level,
    output logic [15:0]      drop_count,
`endif
    output logic [AW:0]      level,
    output logic             overflow
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          drop;
    pixel_t        wdata;
    pixel_t        rdata;
    pixel_t        head;

    assign in_ready  = (level != FULL);
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign drop      = in_valid && !in_ready;

    assign wdata = '{x: in_x, y: in_y, r: in_r, g: in_g, b: in_b};

    pixel_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Stale storage must never leak out while empty.
    assign head  = out_valid ? rdata : '0;
    assign out_x = head.x;
    assign out_y = head.y;
    assign out_r = head.r;
    assign out_g = head.g;
    assign out_b = head.b;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + ONE;
            end else if (pop && !push) begin
                level <= level - ONE;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef PIXEL_WRITE_FIFO_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            max_level  <= '0;
            drop_count <= '0;
        end else begin
            if (level > max_level) begin
                max_level <= level;
            end
            if (drop && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pixel_write_fifo.sv
// Randomised scoreboard bench for pixel_write_fifo.
// Expected pixels are queued at acceptance and checked by a monitor.
module tb_pixel_write_fifo;
    import pixel_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           in_valid = 1'b0;
    logic [7:0]     in_x = '0;
    logic [7:0]     in_y = '0;
    logic [2:0]     in_r = '0;
    logic [2:0]     in_g = '0;
    logic [2:0]     in_b = '0;
    logic           in_ready;
    logic           out_valid;
    logic [7:0]     out_x;
    logic [7:0]     out_y;
    logic [2:0]     out_r;
    logic [2:0]     out_g;
    logic [2:0]     out_b;
    logic           out_ready = 1'b0;
    logic [AW:0]    level;
    logic           overflow;
`ifdef PIXEL_WRITE_FIFO_STATS_EN
    logic [AW:0]    max_level;
    logic [15:0]    drop_count;
`endif

    pixel_write_fifo #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_r       (in_r),
        .in_g       (in_g),
        .in_b       (in_b),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_r      (out_r),
        .out_g      (out_g),
        .out_b      (out_b),
        .out_ready  (out_ready),
`ifdef PIXEL_WRITE_FIFO_STATS_EN
        .max_level  (max_level),
        .drop_count (drop_count),
`endif
        .level      (level),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int     checks = 0;
    int     fails  = 0;
    pixel_t exp_q[$];
    int     m_level = 0;
    bit     m_ovf   = 0;
    int     m_max   = 0;
    int     m_drop  = 0;

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: compares the presented head against the scoreboard.
    always @(negedge clock) begin
        pixel_t got;
        got = '{x: out_x, y: out_y, r: out_r, g: out_g, b: out_b};
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL spurious_out: got %0h expected none", got);
            end else begin
                check("head_pixel", got, exp_q[0]);
                if (out_ready && !reset) void'(exp_q.pop_front());
            end
        end else begin
            check("empty_zero", got, 0);
        end
    end

    // One clock of stimulus; inputs change 1ns after the edge.
    task automatic step(bit v, pixel_t p, bit rdy, bit rst = 0);
        bit acc;
        bit pop;
        reset     = rst;
        in_valid  = v;
        in_x      = p.x;
        in_y      = p.y;
        in_r      = p.r;
        in_g      = p.g;
        in_b      = p.b;
        out_ready = rdy;
        acc = v && (m_level < DEPTH);
        pop = rdy && (m_level > 0);
        @(posedge clock);
        #1;
        if (rst) begin
            m_level = 0;
            m_ovf   = 0;
            m_max   = 0;
            m_drop  = 0;
            exp_q.delete();
        end else begin
            if (m_level > m_max) m_max = m_level;
            if (v && !acc) begin
                m_ovf = 1;
                if (m_drop < 16'hFFFF) m_drop++;
            end
            m_level = m_level + int'(acc) - int'(pop);
            if (acc) exp_q.push_back(p);
        end
        reset    = 0;
        in_valid = 0;
        check("level", level, m_level);
        check("in_ready", in_ready, m_level != DEPTH);
        check("out_valid", out_valid, m_level != 0);
        check("overflow", overflow, m_ovf);
`ifdef PIXEL_WRITE_FIFO_STATS_EN
        check("max_level", max_level, m_max);
        check("drop_count", drop_count, m_drop);
`endif
    endtask

    function automatic pixel_t rnd_pix();
        pixel_t p;
        p = pixel_t'($urandom);
        return p;
    endfunction

    function automatic pixel_t mk(int x);
        pixel_t p;
        p   = rnd_pix();
        p.x = 8'(x);
        return p;
    endfunction

    initial begin
        pixel_t p;
        p = '0;
        step(0, p, 0, 1);
        check("reset_level", level, 0);

        // Single pixel then one pop
        p = '{x: 8'h12, y: 8'h34, r: 3'd3, g: 3'd5, b: 3'd7};
        step(1, p, 0);
        check("t1_x", out_x, 8'h12);
        check("t1_y", out_y, 8'h34);
        step(0, p, 1);
        check("t1_empty", out_valid, 0);

        // Fill, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) step(1, mk(i), 0);
        check("t2_full", level, DEPTH);
        step(1, mk(99), 0);
        check("t2_ovf", overflow, 1);
        for (int i = 0; i < DEPTH; i++) begin
            check("t2_order", out_x, i);
            step(0, p, 1);
        end

        // Streaming across two wraps
        step(0, p, 0, 1);
        for (int i = 0; i < 40; i++) step(1, mk(i), 1);
        check("t3_level", level, 1);
        check("t3_ovf", overflow, 0);
        step(0, p, 1);

        // Full with simultaneous offer and pop
        for (int i = 0; i < DEPTH; i++) step(1, mk(i), 0);
        p = mk(8'hAA);
        step(1, p, 1);
        check("t4_level", level, DEPTH - 1);
        step(1, p, 0);
        check("t4_refill", level, DEPTH);
        for (int i = 0; i < DEPTH; i++) step(0, p, 1);

        // Reset mid-burst with overflow set
        for (int i = 0; i < 9; i++) step(1, mk(i), 0);
        for (int i = 0; i < DEPTH; i++) step(1, mk(i), 0);
        step(0, p, 1);
        for (int i = 0; i < 7; i++) step(0, p, 1);
        check("t5_pre", level, 8);
        step(1, mk(1), 0);
        check("t5_nine", level, 9);
        step(0, p, 0, 1);
        check("t5_level", level, 0);
        check("t5_ovf", overflow, 0);
        p = mk(8'h5C);
        step(1, p, 0);
        check("t5_push", out_x, 8'h5C);
        step(0, p, 1);

        // Stats scenario
        step(0, p, 0, 1);
        for (int i = 0; i < 12; i++) step(1, mk(i), 0);
        for (int i = 0; i < 12; i++) step(0, p, 1);
        for (int i = 0; i < DEPTH; i++) step(1, mk(i), 0);
        for (int i = 0; i < 3; i++) step(1, mk(i), 0);
        step(0, p, 0);
`ifdef PIXEL_WRITE_FIFO_STATS_EN
        check("t6_max", max_level, DEPTH);
        check("t6_drop", drop_count, 3);
`endif
        step(0, p, 0, 1);

        // Random traffic with varying pressure
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = (i / 500) % 3;
            step(($urandom_range(0, 3) != 0) ^ (bias == 2),
                 rnd_pix(),
                 ($urandom_range(0, 3) != 0) ^ (bias == 1));
            if ($urandom_range(0, 999) == 0) step(0, p, 0, 1);
        end
        for (int i = 0; i <= DEPTH; i++) step(0, p, 1);
        check("final_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
